pcie_irq_arbiter: RTL and testbench
===================================

// Module: pcie_irq_arbiter
// PURPOSE
//  Downstream of the rx and tx interrupt generators; sole driver of the endpoint core's cfg_interrupt_n/rdy_n.
//  Arbitrates two requesters on the same active-low req/rdy handshake the core uses.
//  Round-robin or merged grant, a watchdog against a silent core, and a hold-off gap between interrupts.
// PARAMETERS
//  MERGE_EN        1     1: both pending at grant -> one core interrupt acks both; 0: strict round-robin
//  MIN_GAP         2     idle cycles after each ack before next grant (legal 1..255)
//  TIMEOUT_CYCLES  4096  ISSUE cycles without core rdy before forced abort (legal 2..2^16)
//  RX_VECTOR       8'h00 MSI data for rx (and merged) grants; used only with macro
//  TX_VECTOR       8'h01 MSI data for tx grants; used only with macro
// PORTS
//  clk                  in   1  core clock
//  reset                in   1  synchronous, active-high
//  rx_irq_req_n         in   1  rx generator request, held low until rx_irq_rdy_n seen low
//  rx_irq_rdy_n         out  1  one-cycle low ack to rx generator
//  tx_irq_req_n         in   1  tx generator request, same protocol
//  tx_irq_rdy_n         out  1  one-cycle low ack to tx generator
//  cfg_interrupt_n      out  1  request to PCIe endpoint core
//  cfg_interrupt_rdy_n  in   1  core accept, active low
//  cfg_interrupt_di     out  8  MSI vector (present only with IRQ_ARB_MSI_VECTOR_EN)
//  irq_timeout          out  1  one-cycle high pulse on watchdog abort
// BEHAVIOUR
//  Reset: cfg_interrupt_n=1, rx/tx_irq_rdy_n=1, irq_timeout=0, cfg_interrupt_di=0, state IDLE, last_grant=TX.
//   Reset mid-operation drops any in-flight request without acking; requesters re-request after their own reset.
//  All outputs registered. FSM IDLE -> ISSUE -> ACK -> GAP -> IDLE:
//  IDLE: sample req_n. None low: stay. One low: grant it. Both low: MERGE_EN=1 grant both,
//   else grant source != last_grant. Next cycle cfg_interrupt_n=0, timer=0, go ISSUE; last_grant updated
//   (merged grant sets last_grant=TX).
//  ISSUE: cfg_interrupt_n held 0. Sampled cfg_interrupt_rdy_n=0 -> next cycle cfg_interrupt_n=1,
//   granted rdy_n=0, go ACK. Else timer++; timer==TIMEOUT_CYCLES-1 -> same transition plus irq_timeout=1
//   (requesters are still acked to avoid deadlock). rdy_n and timeout at the same sample: rdy_n wins.
//  ACK: exactly one cycle with granted rdy_n=0. Next cycle rdy_n=1, gap=0, go GAP.
//  GAP: requests ignored; gap++; gap==MIN_GAP-1 -> IDLE. Covers the cycle requesters take to release req_n.
//  Latency: req_n low at IDLE sample -> cfg_interrupt_n low 1 cycle later. core rdy_n sample -> requester ack 1 cycle later.
//  Request arriving during ISSUE/ACK/GAP is held by requester; serviced in next IDLE.
//  A request that deasserts before grant is simply not served (no latching inside).
//  Back-to-back throughput: one interrupt per 3+MIN_GAP+core-latency cycles.
//  timer 16 bits, gap 8 bits, both saturate-free within legal parameter range.
// CONFIGURATION
//  IRQ_ARB_MSI_VECTOR_EN defined: cfg_interrupt_di port exists; loaded with the granted vector in the same
//   cycle cfg_interrupt_n goes low; held stable through ISSUE; merged grant uses RX_VECTOR.
//  Undefined: port absent; top level ties core cfg_interrupt_di to 8'h00; RX_VECTOR/TX_VECTOR unused.
// STRUCTURE
//  pcie_irq_arb_pkg: state encodings (IDLE/ISSUE/ACK/GAP), source indices SRC_RX/SRC_TX, default vectors.
//  Sub-module irq_rr_select: combinational 2-way round-robin/merge pick from req mask, last_grant, MERGE_EN;
//   outputs grant mask. FSM, timers, output regs stay in pcie_irq_arbiter.
// TESTING
//  Single rx: rx_req_n low at cycle 10, core rdy_n low 3 cycles after cfg_interrupt_n low -> one rx_rdy_n pulse,
//   tx_rdy_n stays 1, cfg_interrupt_n low exactly 4 cycles.
//  Both pending, MERGE_EN=0: rx+tx low together -> rx served first (after reset), tx second; 2 core interrupts,
//   separated by >= MIN_GAP idle cycles.
//  Both pending, MERGE_EN=1: one core interrupt, rx_rdy_n and tx_rdy_n low in same cycle; di=8'h00 with macro.
//  Silent core, TIMEOUT_CYCLES=16: tx request, rdy_n never low -> cfg_interrupt_n released after 16 cycles,
//   irq_timeout 1-cycle pulse, tx_rdy_n acked.
//  Reset asserted in ISSUE: all outputs 1 next cycle, no ack emitted, FSM in IDLE; re-request serviced normally.
//  rdy_n low on exactly the timeout cycle -> normal ack, irq_timeout stays 0.

Source files
------------

// File: rtl/pcie_irq_arb_pkg.sv
// Shared encodings and constants for the PCIe interrupt arbiter.
package pcie_irq_arb_pkg;

    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned SRC_RX  = 0;
    localparam int unsigned SRC_TX  = 1;
    localparam int unsigned TIMER_W = 16;
    localparam int unsigned GAP_W   = 8;
    localparam int unsigned VEC_W   = 8;

    localparam logic [VEC_W-1:0] DEF_RX_VECTOR = 8'h00;
    localparam logic [VEC_W-1:0] DEF_TX_VECTOR = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    // Tx-only grants carry the tx vector; rx and merged grants carry the rx vector.
    function automatic logic [VEC_W-1:0] grant_vector(input logic [NUM_SRC-1:0] gnt,
                                                      input logic [VEC_W-1:0]   rx_vec,
                                                      input logic [VEC_W-1:0]   tx_vec);
        return (gnt[SRC_TX] && !gnt[SRC_RX]) ? tx_vec : rx_vec;
    endfunction

endpackage

// File: rtl/irq_rr_select.sv
// Two-way round-robin / merge pick over an active-high request mask (combinational).
module irq_rr_select
    import pcie_irq_arb_pkg::*;
#(
    parameter bit MERGE_EN = 1'b1
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic               last_tx_i,
    output logic [NUM_SRC-1:0] gnt_c_o
);

    always_comb begin
        gnt_c_o = '0;
        if (req_i[SRC_RX] && req_i[SRC_TX]) begin
            if (MERGE_EN) begin
                gnt_c_o = '1;
            end else if (last_tx_i) begin
                gnt_c_o[SRC_RX] = 1'b1;
            end else begin
                gnt_c_o[SRC_TX] = 1'b1;
            end
        end else begin
            gnt_c_o = req_i;
        end
    end

endmodule

// File: rtl/pcie_irq_arbiter.sv
// Arbitrates rx/tx interrupt generators onto the endpoint core's cfg_interrupt handshake.
// IRQ_ARB_MSI_VECTOR_EN adds cfg_interrupt_di and the RX_VECTOR/TX_VECTOR parameters.
module pcie_irq_arbiter
    import pcie_irq_arb_pkg::*;
#(
    parameter int unsigned MERGE_EN       = 1,
    parameter int unsigned MIN_GAP        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
`ifdef IRQ_ARB_MSI_VECTOR_EN
    ,
    parameter logic [VEC_W-1:0] RX_VECTOR = DEF_RX_VECTOR,
    parameter logic [VEC_W-1:0] TX_VECTOR = DEF_TX_VECTOR
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_irq_req_n,
    output logic rx_irq_rdy_n,
    input  logic tx_irq_req_n,
    output logic tx_irq_rdy_n,
    output logic cfg_interrupt_n,
    input  logic cfg_interrupt_rdy_n,
    output logic irq_timeout
`ifdef IRQ_ARB_MSI_VECTOR_EN
    ,
    output logic [VEC_W-1:0] cfg_interrupt_di
`endif
);

    arb_state_e           state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [NUM_SRC-1:0]   gnt_q, gnt_d;
    logic                 last_tx_q, last_tx_d;
    logic                 cfg_n_q, cfg_n_d;
    logic                 rx_rdy_n_q, rx_rdy_n_d;
    logic                 tx_rdy_n_q, tx_rdy_n_d;
    logic                 timeout_q, timeout_d;
    logic [NUM_SRC-1:0]   req_c;
    logic [NUM_SRC-1:0]   gnt_c;
`ifdef IRQ_ARB_MSI_VECTOR_EN
    logic [VEC_W-1:0]     di_q, di_d;
`endif

    assign req_c = {~tx_irq_req_n, ~rx_irq_req_n};

    irq_rr_select #(
        .MERGE_EN (MERGE_EN != 0)
    ) u_select (
        .req_i     (req_c),
        .last_tx_i (last_tx_q),
        .gnt_c_o   (gnt_c)
    );

    // Next-state and output decode; acks and the timeout flag are single-cycle pulses.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        gnt_d      = gnt_q;
        last_tx_d  = last_tx_q;
        cfg_n_d    = cfg_n_q;
        rx_rdy_n_d = 1'b1;
        tx_rdy_n_d = 1'b1;
        timeout_d  = 1'b0;
`ifdef IRQ_ARB_MSI_VECTOR_EN
        di_d       = di_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|gnt_c) begin
                    gnt_d     = gnt_c;
                    last_tx_d = gnt_c[SRC_TX];
                    cfg_n_d   = 1'b0;
                    timer_d   = '0;
                    state_d   = ST_ISSUE;
`ifdef IRQ_ARB_MSI_VECTOR_EN
                    di_d      = grant_vector(gnt_c, RX_VECTOR, TX_VECTOR);
`endif
                end
            end
            ST_ISSUE: begin
                // A core accept on the final watchdog cycle is a normal ack, not a timeout.
                if (!cfg_interrupt_rdy_n || (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1))) begin
                    cfg_n_d    = 1'b1;
                    rx_rdy_n_d = ~gnt_q[SRC_RX];
                    tx_rdy_n_d = ~gnt_q[SRC_TX];
                    timeout_d  = cfg_interrupt_rdy_n;
                    state_d    = ST_ACK;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_ACK: begin
                gap_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(MIN_GAP - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            gap_q      <= '0;
            gnt_q      <= '0;
            last_tx_q  <= 1'b1;
            cfg_n_q    <= 1'b1;
            rx_rdy_n_q <= 1'b1;
            tx_rdy_n_q <= 1'b1;
            timeout_q  <= 1'b0;
`ifdef IRQ_ARB_MSI_VECTOR_EN
            di_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            gnt_q      <= gnt_d;
            last_tx_q  <= last_tx_d;
            cfg_n_q    <= cfg_n_d;
            rx_rdy_n_q <= rx_rdy_n_d;
            tx_rdy_n_q <= tx_rdy_n_d;
            timeout_q  <= timeout_d;
`ifdef IRQ_ARB_MSI_VECTOR_EN
            di_q       <= di_d;
`endif
        end
    end

    assign cfg_interrupt_n = cfg_n_q;
    assign rx_irq_rdy_n    = rx_rdy_n_q;
    assign tx_irq_rdy_n    = tx_rdy_n_q;
    assign irq_timeout     = timeout_q;
`ifdef IRQ_ARB_MSI_VECTOR_EN
    assign cfg_interrupt_di = di_q;
`endif

endmodule

// File: tb/tb_pcie_irq_arbiter.sv
// Scoreboard bench: lane 0 runs MERGE_EN=0, lane 1 runs MERGE_EN=1, both with a randomized core.
module tb_pcie_irq_arbiter;

    localparam int unsigned MIN_GAP    = 2;
    localparam int unsigned TMO        = 16;
    localparam int unsigned NEVER      = 1000;
    localparam int unsigned LANE_MERGE = 1;
    localparam logic [7:0]  RXV        = 8'h00;
    localparam logic [7:0]  TXV        = 8'h01;

    typedef struct {
        logic [1:0] mask;
        bit         tmo;
        int         dur;
        bit         b2b;
        logic [7:0] di;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] rx_req_n, tx_req_n, rx_rdy_n, tx_rdy_n, cfg_n, cfg_rdy_n, tmo;
`ifdef IRQ_ARB_MSI_VECTOR_EN
    logic [7:0] di [2];
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q [2][$];
    int   lat_q [2][$];
    int   rx_issue [2];
    int   tx_issue [2];
    int   rx_done [2];
    int   tx_done [2];
    bit   mdl_last_tx [2];

    always #5 clk = ~clk;

    pcie_irq_arbiter #(.MERGE_EN(0), .MIN_GAP(MIN_GAP), .TIMEOUT_CYCLES(TMO)) u_dut_rr (
        .clk(clk), .reset(reset),
        .rx_irq_req_n(rx_req_n[0]), .rx_irq_rdy_n(rx_rdy_n[0]),
        .tx_irq_req_n(tx_req_n[0]), .tx_irq_rdy_n(tx_rdy_n[0]),
        .cfg_interrupt_n(cfg_n[0]), .cfg_interrupt_rdy_n(cfg_rdy_n[0]),
        .irq_timeout(tmo[0])
`ifdef IRQ_ARB_MSI_VECTOR_EN
        , .cfg_interrupt_di(di[0])
`endif
    );

    pcie_irq_arbiter #(.MERGE_EN(1), .MIN_GAP(MIN_GAP), .TIMEOUT_CYCLES(TMO)) u_dut_mg (
        .clk(clk), .reset(reset),
        .rx_irq_req_n(rx_req_n[1]), .rx_irq_rdy_n(rx_rdy_n[1]),
        .tx_irq_req_n(tx_req_n[1]), .tx_irq_rdy_n(tx_rdy_n[1]),
        .cfg_interrupt_n(cfg_n[1]), .cfg_interrupt_rdy_n(cfg_rdy_n[1]),
        .irq_timeout(tmo[1])
`ifdef IRQ_ARB_MSI_VECTOR_EN
        , .cfg_interrupt_di(di[1])
`endif
    );

    // Requesters: hold req_n low while any issued request is still unacked.
    initial begin
        rx_req_n = '1;
        tx_req_n = '1;
        for (int l = 0; l < 2; l++) begin
            rx_done[l] = 0;
            tx_done[l] = 0;
        end
        forever begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (!rx_rdy_n[l]) rx_done[l]++;
                if (!tx_rdy_n[l]) tx_done[l]++;
                rx_req_n[l] = (rx_done[l] >= rx_issue[l]);
                tx_req_n[l] = (tx_done[l] >= tx_issue[l]);
            end
        end
    end

    // Core model: accepts after a per-interrupt latency popped from lat_q.
    initial begin
        int cnt [2];
        int lat [2];
        bit busy [2];
        cfg_rdy_n = '1;
        for (int l = 0; l < 2; l++) begin
            cnt[l] = 0; lat[l] = 0; busy[l] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (!cfg_rdy_n[l]) begin
                    cfg_rdy_n[l] = 1'b1;
                end else if (!cfg_n[l]) begin
                    if (!busy[l]) begin
                        busy[l] = 1'b1;
                        cnt[l]  = 0;
                        lat[l]  = (lat_q[l].size() != 0) ? lat_q[l].pop_front() : int'(NEVER);
                    end
                    cnt[l]++;
                    if (cnt[l] == lat[l]) cfg_rdy_n[l] = 1'b0;
                end else begin
                    busy[l] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int l, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s lane%0d got=%0d want=%0d", name, l, got, want);
        end
    endtask

    // Monitor: reset values, cfg_interrupt_n timing and ack contents against the scoreboard.
    initial begin
        int         lo [2];
        int         hi [2];
        int         dur [2];
        int         gapm [2];
        int         stall [2];
        bit         skip [2];
        logic [1:0] prev_ack [2];
        logic [1:0] ack;
        bit         prev_rst;
        exp_t       e;
        prev_rst = 1'b0;
        for (int l = 0; l < 2; l++) begin
            lo[l] = 0; hi[l] = 0; dur[l] = 0; gapm[l] = 0; stall[l] = 0;
            skip[l] = 1'b1; prev_ack[l] = '0;
        end
        forever begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (prev_rst) begin
                    chk("rst_cfg_n", l, int'(cfg_n[l]), 1);
                    chk("rst_rx_rdy_n", l, int'(rx_rdy_n[l]), 1);
                    chk("rst_tx_rdy_n", l, int'(tx_rdy_n[l]), 1);
                    chk("rst_timeout", l, int'(tmo[l]), 0);
`ifdef IRQ_ARB_MSI_VECTOR_EN
                    chk("rst_di", l, int'(di[l]), 0);
`endif
                end
                if (reset) begin
                    lo[l] = 0; hi[l] = 0; skip[l] = 1'b1; prev_ack[l] = '0;
                    continue;
                end
                ack = {~tx_rdy_n[l], ~rx_rdy_n[l]};
                if (!cfg_n[l]) begin
                    if (lo[l] == 0) begin
                        if (!skip[l]) begin
                            checks++;
                            if (hi[l] < int'(MIN_GAP)) begin
                                errors++;
                                $display("FAIL min_gap lane%0d got=%0d want>=%0d", l, hi[l], MIN_GAP);
                            end
                        end
                        gapm[l] = hi[l];
                        skip[l] = 1'b0;
                    end
                    lo[l]++;
                    hi[l] = 0;
                end else begin
                    if (lo[l] != 0) begin
                        dur[l] = lo[l];
                        lo[l]  = 0;
                    end
                    hi[l]++;
                end
                if (ack != 2'b00) begin
                    stall[l] = 0;
                    if (prev_ack[l] != 2'b00) begin
                        errors++;
                        $display("FAIL ack_width lane%0d got=2+ cycles want=1", l);
                    end else if (exp_q[l].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ack lane%0d got=%0b want=none", l, ack);
                    end else begin
                        e = exp_q[l].pop_front();
                        chk("ack_mask", l, int'(ack), int'(e.mask));
                        chk("timeout", l, int'(tmo[l]), int'(e.tmo));
                        chk("cfg_low_cycles", l, dur[l], e.dur);
                        if (e.b2b) chk("b2b_high_cycles", l, gapm[l], int'(MIN_GAP) + 2);
`ifdef IRQ_ARB_MSI_VECTOR_EN
                        chk("di", l, int'(di[l]), int'(e.di));
`endif
                    end
                end else begin
                    if (tmo[l]) begin
                        errors++;
                        $display("FAIL stray_timeout lane%0d got=1 want=0", l);
                    end
                    if (exp_q[l].size() != 0) begin
                        stall[l]++;
                        if (stall[l] > 300) begin
                            errors++;
                            $display("FAIL no_ack lane%0d got=none want=%0d pending", l, exp_q[l].size());
                            exp_q[l].delete();
                            stall[l] = 0;
                        end
                    end else begin
                        stall[l] = 0;
                    end
                end
                prev_ack[l] = ack;
            end
            prev_rst = reset;
        end
    end

    task automatic push_exp(input int l, input logic [1:0] mask, input int lat, input bit b2b);
        exp_t e;
        e.mask = mask;
        e.tmo  = (lat > int'(TMO));
        e.dur  = (lat > int'(TMO)) ? int'(TMO) : lat;
        e.b2b  = b2b;
        e.di   = (mask == 2'b10) ? TXV : RXV;
        exp_q[l].push_back(e);
        lat_q[l].push_back(lat);
    endtask

    // Reference model: order of service for requests raised together at an idle arbiter.
    task automatic issue(input int l, input bit rx, input bit tx, input int lat_a, input int lat_b);
        if (rx && tx) begin
            if (l == int'(LANE_MERGE)) begin
                push_exp(l, 2'b11, lat_a, 1'b0);
                mdl_last_tx[l] = 1'b1;
            end else if (mdl_last_tx[l]) begin
                push_exp(l, 2'b01, lat_a, 1'b0);
                push_exp(l, 2'b10, lat_b, 1'b1);
                mdl_last_tx[l] = 1'b1;
            end else begin
                push_exp(l, 2'b10, lat_a, 1'b0);
                push_exp(l, 2'b01, lat_b, 1'b1);
                mdl_last_tx[l] = 1'b0;
            end
        end else if (rx) begin
            push_exp(l, 2'b01, lat_a, 1'b0);
            mdl_last_tx[l] = 1'b0;
        end else begin
            push_exp(l, 2'b10, lat_a, 1'b0);
            mdl_last_tx[l] = 1'b1;
        end
        if (rx) rx_issue[l]++;
        if (tx) tx_issue[l]++;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            $display("FAIL drain_timeout got=%0d/%0d pending want=0", exp_q[0].size(), exp_q[1].size());
            $fatal(1, "scoreboard did not drain");
        end
        repeat (MIN_GAP + 3) @(negedge clk);
    endtask

    function automatic int rand_lat();
        int r = int'($urandom_range(0, 9));
        if (r < 7) return int'($urandom_range(1, 6));
        if (r == 7) return int'(TMO);
        if (r == 8) return int'(TMO) - 1;
        return int'(TMO) + 1 + int'($urandom_range(0, 20));
    endfunction

    initial begin
        int n;
        reset = 1'b1;
        for (int l = 0; l < 2; l++) begin
            rx_issue[l] = 0; tx_issue[l] = 0; mdl_last_tx[l] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(negedge clk);

        for (int l = 0; l < 2; l++) issue(l, 1'b1, 1'b0, 4, 0);
        drain();
        for (int l = 0; l < 2; l++) issue(l, 1'b1, 1'b1, 3, 5);
        drain();
        for (int l = 0; l < 2; l++) issue(l, 1'b0, 1'b1, int'(NEVER), 0);
        drain();
        for (int l = 0; l < 2; l++) issue(l, 1'b1, 1'b0, int'(TMO), 0);
        drain();

        // Reset in ISSUE: the in-flight tx request is dropped, then re-served after reset.
        for (int l = 0; l < 2; l++) begin
            lat_q[l].push_back(int'(NEVER));
            tx_issue[l]++;
        end
        n = 0;
        while (cfg_n != 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int l = 0; l < 2; l++) begin
            mdl_last_tx[l] = 1'b1;
            push_exp(l, 2'b10, 3, 1'b0);
        end
        drain();

        for (int s = 0; s < 40; s++) begin
            for (int l = 0; l < 2; l++) begin
                int sel = int'($urandom_range(1, 3));
                issue(l, sel[0], sel[1], rand_lat(), rand_lat());
            end
            drain();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
